change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//   Downstream of VMControl: converts its change request (ret_coin level + ret_value amount)
//   into a paced train of coin-eject pulses for the ten-yuan and one-yuan hoppers.
//   Greedy: all ten-yuan coins first, then one-yuan coins. Reports busy/done and the
//   amount still owed so the display path can show the count-down.
// PARAMETERS
//   VALUE_W       8   width of ret_value / remaining
//   PULSE_CYCLES  4   cycles an eject output is held high per coin (>=1)
//   GAP_CYCLES    4   low cycles after each eject pulse before the next coin (>=1)
// PORTS
//   clk         in   1        system clock; all state on rising edge
//   rst         in   1        asynchronous, active-high reset
//   ret_coin    in   1        change request level from VMControl; rising edge starts a job
//   ret_value   in   VALUE_W  change amount in yuan, sampled on the ret_coin rising edge
//   eject_ten   out  1        ten-yuan hopper eject pulse
//   eject_one   out  1        one-yuan hopper eject pulse
//   busy        out  1        job in progress (first pulse cycle through done cycle)
//   done        out  1        single-cycle strobe: job complete
//   remaining   out  VALUE_W  yuan still to dispense; 0 when idle
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE; eject_ten=eject_one=busy=done=0; remaining=0;
//     ret_coin edge register=0 and timer=0. Pending change is discarded; not resumed.
//   Edge detect: start = ret_coin & ~ret_coin_q. ret_coin already high when rst falls
//     produces one start. Holding ret_coin high never retriggers.
//   States: IDLE, TEN_HI, TEN_LO, ONE_HI, ONE_LO, DONE.
//   IDLE: on start (cycle N) latch remaining<=ret_value; next state from the latched value:
//     >=10 -> TEN_HI, 1..9 -> ONE_HI, 0 -> DONE. First pulse/busy visible at N+1.
//   TEN_HI/ONE_HI: matching eject output high for exactly PULSE_CYCLES cycles; on the
//     last HI cycle remaining decrements by 10 (ten) or 1 (one); go to *_LO.
//   TEN_LO/ONE_LO: both ejects low for GAP_CYCLES cycles; on the last cycle choose:
//     remaining>=10 -> TEN_HI, remaining>0 -> ONE_HI, else DONE.
//   DONE: one cycle, done=1, busy=1, ejects low; then IDLE (busy=0).
//   Outputs are registered (Moore); eject_ten and eject_one never high together.
//   Timing: coins = ret_value/10 + ret_value%10; job length from start =
//     coins*(PULSE_CYCLES+GAP_CYCLES) + 1 cycles (DONE); value 0 -> done at N+1.
//   Arithmetic: unsigned VALUE_W; decrement only when remaining >= step, so no wrap;
//     max 255 -> 25 ten + 5 one coins.
//   start while busy (new rising edge): ignored, no latch of ret_value, job continues.
//   start in the DONE cycle: ignored (edge consumed); VMControl re-raises for a new job.
//   ret_value changes after the start cycle: no effect on the running job.
// STRUCTURE
//   vm_pkg: state encoding localparams (IDLE..DONE), COIN_TEN=10, COIN_ONE=1 — shared
//     with VMControl/coin_collector coin constants.
//   Sub-module pulse_timer: loadable down-counter (load value, tick, expire flag) used
//     for both HI and LO phase lengths; FSM, edge detect and remaining register in the top.
// TESTING (PULSE_CYCLES=2, GAP_CYCLES=2 unless noted)
//   ret_value=23, ret_coin rises at cycle 0 -> eject_ten high 1-2, 5-6; eject_one high
//     9-10,13-14,17-18; remaining 23,13,3,2,1,0 stepping on cycles 2,6,10,14,18; done=1 at 21.
//   ret_value=0 -> no eject pulses, busy=1 and done=1 at cycle 1 only, remaining stays 0.
//   ret_value=255 -> exactly 25 eject_ten then 5 eject_one pulses, done at cycle 121, no overlap.
//   ret_coin held high across a whole job and a second rising edge mid-job (value 7) ->
//     single job of the original amount only; no second job after done.
//   rst asserted during TEN_HI of a 40-yuan job -> all outputs 0 in the same cycle,
//     no further pulses; next rising edge with ret_value=5 -> fresh 5-coin job.
//   PULSE_CYCLES=1, GAP_CYCLES=1, ret_value=10 -> eject_ten high exactly cycle 1, done at cycle 3.

Source files
------------

// File: rtl/vm_pkg.sv
// vm_pkg: dispenser state encoding and coin denominations.
// Shared with VMControl and coin_collector.
`default_nettype none

package vm_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      TEN_HI = 3'd1,
      TEN_LO = 3'd2,
      ONE_HI = 3'd3,
      ONE_LO = 3'd4,
      DONE   = 3'd5
   } state_t;

   localparam int COIN_TEN = 10;
   localparam int COIN_ONE = 1;

endpackage

`default_nettype wire

// File: rtl/pulse_timer.sv
// pulse_timer: loadable down-counter that times the eject HI and gap LO phases.
// Load value N gives N+1 cycles before the phase ends.
`default_nettype none

module pulse_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         tick,
   output logic         expired
);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (tick && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign expired = (count == '0);

endmodule

`default_nettype wire

// File: rtl/change_dispenser.sv
// change_dispenser: turns a change request into paced ten-yuan then one-yuan eject pulses.
// Outputs are registered from the next state, so they are glitch-free Moore outputs.
`default_nettype none

module change_dispenser
   import vm_pkg::*;
#(
   parameter int VALUE_W      = 8,
   parameter int PULSE_CYCLES = 4,
   parameter int GAP_CYCLES   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ret_coin,
   input  logic [VALUE_W-1:0] ret_value,
   output logic               eject_ten,
   output logic               eject_one,
   output logic               busy,
   output logic               done,
   output logic [VALUE_W-1:0] remaining
);

   localparam int TIMER_W = 8;
   localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);
   localparam logic [VALUE_W-1:0] TEN_V      = VALUE_W'(COIN_TEN);
   localparam logic [VALUE_W-1:0] ONE_V      = VALUE_W'(COIN_ONE);

   state_t               state;
   state_t               state_next;
   logic                 ret_coin_q;
   logic                 start;
   logic [VALUE_W-1:0]   remaining_next;
   logic                 timer_load;
   logic                 timer_tick;
   logic [TIMER_W-1:0]   timer_value;
   logic                 timer_expired;

   assign start = ret_coin & ~ret_coin_q;

   // Greedy choice of the next coin for the amount still owed.
   function automatic state_t pick_coin(input logic [VALUE_W-1:0] amount);
      if (amount >= TEN_V)
         return TEN_HI;
      else if (amount != '0)
         return ONE_HI;
      else
         return DONE;
   endfunction

   pulse_timer #(
      .W (TIMER_W)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (timer_load),
      .load_value (timer_value),
      .tick       (timer_tick),
      .expired    (timer_expired)
   );

   always_comb begin
      state_next     = state;
      remaining_next = remaining;
      timer_load     = 1'b0;
      timer_tick     = 1'b0;
      timer_value    = PULSE_LOAD;
      case (state)
         IDLE: begin
            if (start) begin
               remaining_next = ret_value;
               state_next     = pick_coin(ret_value);
               timer_load     = 1'b1;
            end
         end
         TEN_HI, ONE_HI: begin
            timer_tick = 1'b1;
            if (timer_expired) begin
               if (state == TEN_HI) begin
                  if (remaining >= TEN_V) remaining_next = remaining - TEN_V;
                  state_next = TEN_LO;
               end else begin
                  if (remaining >= ONE_V) remaining_next = remaining - ONE_V;
                  state_next = ONE_LO;
               end
               timer_load  = 1'b1;
               timer_value = GAP_LOAD;
            end
         end
         TEN_LO, ONE_LO: begin
            timer_tick = 1'b1;
            if (timer_expired) begin
               state_next = pick_coin(remaining);
               timer_load = 1'b1;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The edge register samples every cycle, so edges seen while busy are consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ret_coin_q <= 1'b0;
         remaining  <= '0;
         eject_ten  <= 1'b0;
         eject_one  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_next;
         ret_coin_q <= ret_coin;
         remaining  <= remaining_next;
         eject_ten  <= (state_next == TEN_HI);
         eject_one  <= (state_next == ONE_HI);
         busy       <= (state_next != IDLE);
         done       <= (state_next == DONE);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: randomized jobs checked cycle by cycle against an arithmetic coin-schedule model.
`default_nettype none

module tb_change_dispenser;

   localparam int VW = 8;
   localparam int P  = 2;
   localparam int G  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          a_ret_coin = 1'b0;
   logic [VW-1:0] a_ret_value = '0;
   logic          a_eject_ten, a_eject_one, a_busy, a_done;
   logic [VW-1:0] a_remaining;
   logic          b_ret_coin = 1'b0;
   logic [VW-1:0] b_ret_value = '0;
   logic          b_eject_ten, b_eject_one, b_busy, b_done;
   logic [VW-1:0] b_remaining;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   change_dispenser #(.VALUE_W(VW), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut_a (
      .clk(clk), .rst(rst), .ret_coin(a_ret_coin), .ret_value(a_ret_value),
      .eject_ten(a_eject_ten), .eject_one(a_eject_one), .busy(a_busy),
      .done(a_done), .remaining(a_remaining)
   );

   change_dispenser #(.VALUE_W(VW), .PULSE_CYCLES(1), .GAP_CYCLES(1)) dut_b (
      .clk(clk), .rst(rst), .ret_coin(b_ret_coin), .ret_value(b_ret_value),
      .eject_ten(b_eject_ten), .eject_one(b_eject_one), .busy(b_busy),
      .done(b_done), .remaining(b_remaining)
   );

   // Runs one job of value v on dut_a. Cycle t=1 is the first cycle after the start edge.
   task automatic run_job(input int v, input bit raise, input bit glitch);
      int period, tens, coins, len, fin, rem, c, ph;
      logic e_ten, e_one, e_busy, e_done;
      logic [VW-1:0] e_rem;
      period = P + G;
      tens   = v / 10;
      coins  = v / 10 + v % 10;
      len    = coins * period + 1;
      if (raise) begin
         @(posedge clk); #1;
         a_ret_value = VW'(v);
         a_ret_coin  = 1'b1;
      end
      for (int t = 1; t <= len + 3; t++) begin
         @(posedge clk); #1;
         e_ten = 1'b0; e_one = 1'b0; e_busy = 1'b0; e_done = 1'b0; rem = 0;
         if (t <= len) begin
            e_busy = 1'b1;
            e_done = (t == len);
            if (t < len) begin
               c  = (t - 1) / period;
               ph = (t - 1) % period;
               e_ten = (ph < P) && (c < tens);
               e_one = (ph < P) && (c >= tens);
            end
            fin = (t - 1 - P >= 0) ? ((t - 1 - P) / period + 1) : 0;
            if (fin > coins) fin = coins;
            rem = v - 10 * ((fin < tens) ? fin : tens) - ((fin > tens) ? (fin - tens) : 0);
         end
         e_rem = VW'(rem);
         checks += 6;
         if (a_eject_ten !== e_ten) begin errors++;
            $display("FAIL job v=%0d t=%0d eject_ten got %b want %b", v, t, a_eject_ten, e_ten); end
         if (a_eject_one !== e_one) begin errors++;
            $display("FAIL job v=%0d t=%0d eject_one got %b want %b", v, t, a_eject_one, e_one); end
         if (a_busy !== e_busy) begin errors++;
            $display("FAIL job v=%0d t=%0d busy got %b want %b", v, t, a_busy, e_busy); end
         if (a_done !== e_done) begin errors++;
            $display("FAIL job v=%0d t=%0d done got %b want %b", v, t, a_done, e_done); end
         if (a_remaining !== e_rem) begin errors++;
            $display("FAIL job v=%0d t=%0d remaining got %0d want %0d", v, t, a_remaining, e_rem); end
         if ((a_eject_ten & a_eject_one) !== 1'b0) begin errors++;
            $display("FAIL job v=%0d t=%0d overlap got %b want 0", v, t, a_eject_ten & a_eject_one); end
         a_ret_value = VW'($urandom);
         if (glitch && t == 5) a_ret_coin = 1'b0;
         if (glitch && t == 6) begin a_ret_coin = 1'b1; a_ret_value = 8'd7; end
      end
      a_ret_coin = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #1;
      checks += 2;
      if ({a_eject_ten, a_eject_one, a_busy, a_done, a_remaining} !== 12'd0) begin errors++;
         $display("FAIL reset dut_a outputs got %h want 0", {a_eject_ten, a_eject_one, a_busy, a_done, a_remaining}); end
      if ({b_eject_ten, b_eject_one, b_busy, b_done, b_remaining} !== 12'd0) begin errors++;
         $display("FAIL reset dut_b outputs got %h want 0", {b_eject_ten, b_eject_one, b_busy, b_done, b_remaining}); end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_example();
      run_job(23, 1'b1, 1'b0);
   endtask

   task automatic test_zero();
      run_job(0, 1'b1, 1'b0);
   endtask

   task automatic test_max();
      run_job(255, 1'b1, 1'b0);
   endtask

   task automatic test_hold_retrigger();
      run_job(int'($urandom_range(2, 99)), 1'b1, 1'b1);
   endtask

   task automatic test_random();
      int v;
      for (int i = 0; i < 6; i++) begin
         v = int'($urandom_range(0, 255));
         run_job(v, 1'b1, (v >= 2) ? 1'b1 : 1'b0);
      end
   endtask

   task automatic test_reset_midjob();
      @(posedge clk); #1;
      a_ret_value = 8'd40;
      a_ret_coin  = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (a_eject_ten !== 1'b1) begin errors++;
         $display("FAIL midreset pre eject_ten got %b want 1", a_eject_ten); end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({a_eject_ten, a_eject_one, a_busy, a_done, a_remaining} !== 12'd0) begin errors++;
         $display("FAIL midreset async outputs got %h want 0", {a_eject_ten, a_eject_one, a_busy, a_done, a_remaining}); end
      a_ret_coin = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({a_eject_ten, a_eject_one, a_busy, a_done} !== 4'd0) begin errors++;
            $display("FAIL midreset quiet cyc=%0d got %b want 0000", i, {a_eject_ten, a_eject_one, a_busy, a_done}); end
      end
      run_job(5, 1'b1, 1'b0);
   endtask

   task automatic test_start_at_reset_release();
      @(posedge clk); #1;
      rst = 1'b1;
      a_ret_coin  = 1'b1;
      a_ret_value = 8'd3;
      @(posedge clk); #1;
      rst = 1'b0;
      run_job(3, 1'b0, 1'b0);
   endtask

   task automatic test_min_timing();
      @(posedge clk); #1;
      b_ret_value = 8'd10;
      b_ret_coin  = 1'b1;
      for (int t = 1; t <= 6; t++) begin
         @(posedge clk); #1;
         checks += 5;
         if (b_eject_ten !== (t == 1)) begin errors++;
            $display("FAIL min t=%0d eject_ten got %b want %b", t, b_eject_ten, (t == 1)); end
         if (b_eject_one !== 1'b0) begin errors++;
            $display("FAIL min t=%0d eject_one got %b want 0", t, b_eject_one); end
         if (b_done !== (t == 3)) begin errors++;
            $display("FAIL min t=%0d done got %b want %b", t, b_done, (t == 3)); end
         if (b_busy !== (t <= 3)) begin errors++;
            $display("FAIL min t=%0d busy got %b want %b", t, b_busy, (t <= 3)); end
         if (b_remaining !== ((t == 1) ? 8'd10 : 8'd0)) begin errors++;
            $display("FAIL min t=%0d remaining got %0d want %0d", t, b_remaining, (t == 1) ? 10 : 0); end
      end
      b_ret_coin = 1'b0;
   endtask

   initial begin
      test_reset();
      test_example();
      test_zero();
      test_max();
      test_hold_retrigger();
      test_random();
      test_reset_midjob();
      test_start_at_reset_release();
      test_min_timing();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
